audio_adc_rx: RTL and testbench

Serial audio receiver for the WM8731 ADC path on the DE2 board. It is the receive-side counterpart of the `audio_codec` DAC transmitter. The block samples the codec's `AUD_BCLK`, `AUD_ADCLRCK` and `AUD_ADCDAT` pins in the `sys_clk` domain and deserialises standard I2S frames (MSB first, one-bit delay after each LRCK edge, LRCK low = left). It presents each complete left/right pair as parallel words with a one-cycle valid strobe.

---
 rtl/audio_adc_rx.sv | 121 ++++++++++++
 tb/tb_audio_adc_rx.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/audio_adc_rx.sv
// I2S receiver for the WM8731 ADC path: synchronises the codec pins into sys_clk
// and deserialises left/right words, MSB first with the one-bit I2S delay slot.
module audio_adc_rx #(
  parameter int DATA_WIDTH = 24
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic                  bclk,
  input  logic                  adclrc,
  input  logic                  adcdat,
  output logic [DATA_WIDTH-1:0] data_left,
  output logic [DATA_WIDTH-1:0] data_right,
  output logic                  sample_valid,
  output logic                  frame_err
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;

  logic [1:0]            bclk_sync;
  logic                  bclk_d;
  logic [1:0]            lrc_sync;
  logic [1:0]            dat_sync;
  logic                  bclk_rise;
  logic                  lrc;
  logic                  dat;
  logic                  lrc_prev;
  logic                  boundary;
  logic                  short_word;
  logic [CW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] bit_mask;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] left_hold;
  state_t                state;

  always_ff @(posedge sys_clk) begin
    if (!rst) begin
      bclk_sync <= '0;
      bclk_d    <= 1'b0;
      lrc_sync  <= '0;
      dat_sync  <= '0;
    end else begin
      bclk_sync <= {bclk_sync[0], bclk};
      bclk_d    <= bclk_sync[1];
      lrc_sync  <= {lrc_sync[0], adclrc};
      dat_sync  <= {dat_sync[0], adcdat};
    end
  end

  assign bclk_rise  = bclk_sync[1] & ~bclk_d;
  assign lrc        = lrc_sync[1];
  assign dat        = dat_sync[1];
  assign boundary   = bclk_rise && (lrc != lrc_prev);
  assign short_word = (bit_cnt != CW'(DATA_WIDTH));

  // bit_mask walks from the MSB down so a short word stays left-aligned with zero LSBs
  always_ff @(posedge sys_clk) begin
    if (!rst) begin
      lrc_prev  <= 1'b0;
      bit_cnt   <= '0;
      bit_mask  <= '0;
      shift_reg <= '0;
    end else if (bclk_rise) begin
      lrc_prev <= lrc;
      if (lrc != lrc_prev) begin
        bit_cnt   <= '0;
        bit_mask  <= {1'b1, {(DATA_WIDTH-1){1'b0}}};
        shift_reg <= '0;
      end else if (short_word) begin
        bit_cnt  <= bit_cnt + CW'(1);
        bit_mask <= bit_mask >> 1;
        if (dat) begin
          shift_reg <= shift_reg | bit_mask;
        end
      end
    end
  end

  // Channel words are taken at the boundary rise, before the shift register clears
  always_ff @(posedge sys_clk) begin
    if (!rst) begin
      state        <= IDLE;
      left_hold    <= '0;
      data_left    <= '0;
      data_right   <= '0;
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
      if (boundary) begin
        case (state)
          IDLE: begin
            if (!lrc) begin
              state <= LEFT;
            end
          end
          LEFT: begin
            if (lrc) begin
              left_hold <= shift_reg;
              frame_err <= short_word;
              state     <= RIGHT;
            end
          end
          RIGHT: begin
            if (!lrc) begin
              data_left    <= left_hold;
              data_right   <= shift_reg;
              sample_valid <= 1'b1;
              frame_err    <= short_word;
              state        <= LEFT;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_audio_adc_rx.sv
// Self-checking bench for audio_adc_rx: drives I2S frames on the codec pins
// and compares every reported pair against hand-computed words.
`timescale 1ns/1ps
module tb_audio_adc_rx;

  localparam int DW      = 24;
  localparam int HALF_NS = 100;

  logic          sys_clk = 1'b0;
  logic          rst     = 1'b0;
  logic          bclk    = 1'b0;
  logic          adclrc  = 1'b0;
  logic          adcdat  = 1'b0;
  logic [DW-1:0] data_left;
  logic [DW-1:0] data_right;
  logic          sample_valid;
  logic          frame_err;

  audio_adc_rx #(.DATA_WIDTH(DW)) dut (
    .sys_clk     (sys_clk),
    .rst         (rst),
    .bclk        (bclk),
    .adclrc      (adclrc),
    .adcdat      (adcdat),
    .data_left   (data_left),
    .data_right  (data_right),
    .sample_valid(sample_valid),
    .frame_err   (frame_err)
  );

  always #10 sys_clk = ~sys_clk;

  typedef struct {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
    logic          err;
    int            cyc;
  } pulse_t;

  typedef struct {
    logic [DW-1:0] left;
    logic [DW-1:0] right;
    int            slots;
    logic [DW-1:0] exp_left;
    logic [DW-1:0] exp_right;
    logic          exp_err;
  } vec_t;

  int            checks     = 0;
  int            errors     = 0;
  int            cyc        = 0;
  int            err_pulses = 0;
  int            width_viol = 0;
  int            hold_viol  = 0;
  pulse_t        got[$];
  logic          prev_valid = 1'b0;
  logic          prev_err   = 1'b0;
  logic          prev_rst   = 1'b0;
  logic [DW-1:0] prev_l     = '0;
  logic [DW-1:0] prev_r     = '0;

  always @(posedge sys_clk) cyc++;

  // Collect every pulse and watch pulse widths and output stability between pulses
  always @(negedge sys_clk) begin
    if (sample_valid === 1'b1) got.push_back('{data_left, data_right, frame_err, cyc});
    if (frame_err === 1'b1) err_pulses++;
    if ((sample_valid && prev_valid) || (frame_err && prev_err)) width_viol++;
    if (rst && prev_rst && !sample_valid && (data_left != prev_l || data_right != prev_r))
      hold_viol++;
    prev_valid = sample_valid;
    prev_err   = frame_err;
    prev_rst   = rst;
    prev_l     = data_left;
    prev_r     = data_right;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pulse_reset(input int n);
    @(posedge sys_clk);
    #2 rst = 1'b0;
    repeat (n) @(posedge sys_clk);
    #2 rst = 1'b1;
  endtask

  task automatic bclk_half(input bit jitter);
    if (jitter) #($urandom_range(HALF_NS - 20, HALF_NS + 20));
    else #(HALF_NS);
  endtask

  // One channel: slot 0 is the delay slot, slots 1..DW carry the word MSB first
  task automatic apply_stimulus(input logic lrc, input logic [DW-1:0] word, input int slots,
                                input int rst_slot, input bit jitter);
    for (int i = 0; i < slots; i++) begin
      bclk   = 1'b0;
      adclrc = lrc;
      if (i >= 1 && i <= DW) adcdat = word[DW-i];
      else adcdat = 1'($urandom_range(0, 1));
      if (i == rst_slot) begin
        pulse_reset(1);
        check_output("midframe_reset_left", data_left, 0);
        check_output("midframe_reset_right", data_right, 0);
      end
      bclk_half(jitter);
      bclk = 1'b1;
      bclk_half(jitter);
    end
  endtask

  vec_t          vecs[5];
  logic [DW-1:0] exp_l[$];
  logic [DW-1:0] exp_r[$];
  logic [DW-1:0] rl;
  logic [DW-1:0] rr;
  int            base;
  int            err_base;

  initial begin
    vecs[0] = '{24'hA5C396, 24'h123456, 32, 24'hA5C396, 24'h123456, 1'b0};
    vecs[1] = '{24'h55E7FF, 24'hFFFFFF, 16, 24'h55E600, 24'hFFFE00, 1'b1};
    vecs[2] = '{24'h7FFFFF, 24'h800000, 32, 24'h7FFFFF, 24'h800000, 1'b0};
    vecs[3] = '{24'h000001, 24'hFFFFFF, 32, 24'h000001, 24'hFFFFFF, 1'b0};
    vecs[4] = '{24'h800000, 24'h7FFFFF, 32, 24'h800000, 24'h7FFFFF, 1'b0};

    #5;
    repeat (5) @(posedge sys_clk);
    #2;
    check_output("reset_data_left", data_left, 0);
    check_output("reset_data_right", data_right, 0);
    check_output("reset_sample_valid", sample_valid, 0);
    check_output("reset_frame_err", frame_err, 0);
    rst = 1'b1;

    // Lock onto a stream that starts in the middle of a right channel
    apply_stimulus(1'b1, 24'hFFFFFF, 12, -1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        check_output("lock_no_pulse", got.size(), 0);
        check_output("lock_data_left", data_left, 0);
      end
      apply_stimulus(1'b0, vecs[i].left, vecs[i].slots, -1, 1'b0);
      apply_stimulus(1'b1, vecs[i].right, vecs[i].slots, -1, 1'b0);
    end
    apply_stimulus(1'b0, 24'h000000, 32, -1, 1'b0);
    repeat (5) @(posedge sys_clk);

    check_output("table_pulse_count", got.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < got.size()) begin
        check_output($sformatf("vec%0d_left", i), got[i].l, vecs[i].exp_left);
        check_output($sformatf("vec%0d_right", i), got[i].r, vecs[i].exp_right);
        check_output($sformatf("vec%0d_err", i), got[i].err, vecs[i].exp_err);
      end
    end
    check_output("table_err_pulses", err_pulses, 2);
    if (got.size() == 5) begin
      check_output("b2b_period_1", got[3].cyc - got[2].cyc, 640);
      check_output("b2b_period_2", got[4].cyc - got[3].cyc, 640);
    end

    // Reset at bit 10 of a right channel drops that pair entirely
    base = got.size();
    apply_stimulus(1'b0, 24'h111111, 32, -1, 1'b0);
    apply_stimulus(1'b1, 24'h222222, 32, 11, 1'b0);
    apply_stimulus(1'b0, 24'h3C3C3C, 32, -1, 1'b0);
    apply_stimulus(1'b1, 24'hC3C3C3, 32, -1, 1'b0);
    apply_stimulus(1'b0, 24'h000000, 32, -1, 1'b0);
    repeat (5) @(posedge sys_clk);
    check_output("rst_pulse_count", got.size() - base, 1);
    if (got.size() > base) begin
      check_output("rst_next_left", got[base].l, 24'h3C3C3C);
      check_output("rst_next_right", got[base].r, 24'hC3C3C3);
    end

    // Random pairs with bclk edges jittered against sys_clk
    pulse_reset(5);
    apply_stimulus(1'b1, 24'h000000, 7, -1, 1'b1);
    base     = got.size();
    err_base = err_pulses;
    for (int k = 0; k < 100; k++) begin
      rl = DW'($urandom);
      rr = DW'($urandom);
      exp_l.push_back(rl);
      exp_r.push_back(rr);
      apply_stimulus(1'b0, rl, 26, -1, 1'b1);
      apply_stimulus(1'b1, rr, 26, -1, 1'b1);
    end
    apply_stimulus(1'b0, 24'h000000, 26, -1, 1'b1);
    repeat (10) @(posedge sys_clk);
    check_output("jitter_pulse_count", got.size() - base, 100);
    for (int k = 0; k < 100; k++) begin
      if (base + k < got.size()) begin
        check_output($sformatf("jitter%0d_left", k), got[base+k].l, exp_l[k]);
        check_output($sformatf("jitter%0d_right", k), got[base+k].r, exp_r[k]);
      end
    end
    check_output("jitter_frame_err", err_pulses - err_base, 0);

    check_output("pulse_width", width_viol, 0);
    check_output("data_hold", hold_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
